// File: rtl/pipeline_pkg.sv
// Shared MIPS pipeline definitions: control-bit positions, fixed register
// numbers and the write-back source decode.
package pipeline_pkg;

    localparam int unsigned CTL_REGWRITE = 0;
    localparam int unsigned CTL_MEMTOREG = 1;
    localparam int unsigned CTL_LINK     = 2;

    localparam int unsigned LINK_REG  = 31;
    localparam int unsigned ZERO_REG  = 0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        WbSelAlu,
        WbSelMem,
        WbSelLink
    } wb_sel_e;

    // Link outranks MemtoReg.
    function automatic wb_sel_e wb_select(input logic [2:0] ctl);
        if (ctl[CTL_LINK]) begin
            return WbSelLink;
        end else if (ctl[CTL_MEMTOREG]) begin
            return WbSelMem;
        end
        return WbSelAlu;
    endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// MEM/WB inputs, decode read ports and forwarding outputs of the write-back stage.
interface writeback_regfile_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
);
    logic [ADDR_W-1:0] RegDestAddress;
    logic [DATA_W-1:0] ReadDataRam;
    logic [DATA_W-1:0] AluResult;
    logic [DATA_W-1:0] Instruction;
    logic [DATA_W-1:0] PC;
    logic [2:0]        ControlSignals;
    logic [ADDR_W-1:0] ReadAddr1;
    logic [ADDR_W-1:0] ReadAddr2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] WbData;
    logic [ADDR_W-1:0] WbAddr;
    logic              WbEnable;
    logic [CNT_W-1:0]  RetiredCount;

    modport master (
        output RegDestAddress, ReadDataRam, AluResult, Instruction, PC, ControlSignals,
        output ReadAddr1, ReadAddr2,
        input  ReadData1, ReadData2, WbData, WbAddr, WbEnable, RetiredCount
    );

    modport slave (
        input  RegDestAddress, ReadDataRam, AluResult, Instruction, PC, ControlSignals,
        input  ReadAddr1, ReadAddr2,
        output ReadData1, ReadData2, WbData, WbAddr, WbEnable, RetiredCount
    );
endinterface

// File: rtl/regfile_core.sv
// General-purpose register array: one write port, two combinational read
// ports with write-through bypass; register 0 is hardwired to zero.
module regfile_core
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);
    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic              we_eff;

    assign we_eff = we_i && (waddr_i != ZeroAddr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_eff) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Bypass lets decode see the value being committed on this edge.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] raddr);
        if (raddr == ZeroAddr) begin
            return '0;
        end else if (we_eff && (raddr == waddr_i)) begin
            return wdata_i;
        end
        return regs_q[raddr];
    endfunction

    always_comb begin
        rdata1_o = read_port(raddr1_i);
        rdata2_o = read_port(raddr2_i);
    end

endmodule

// File: rtl/writeback_regfile.sv
// MIPS write-back stage: result select, write-enable gating, register file
// and retired-instruction counter.
module writeback_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LINK_REG = pipeline_pkg::LINK_REG,
    parameter int unsigned CNT_W    = 32
) (
    input logic                clk,
    input logic                reset,
    writeback_regfile_if.slave bus
);
    import pipeline_pkg::*;

    wb_sel_e           wb_sel;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_en;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign wb_sel = wb_select(bus.ControlSignals);

    always_comb begin
        wb_data = bus.AluResult;
        wb_addr = bus.RegDestAddress;
        case (wb_sel)
            WbSelLink: begin
                // No delay slot: the return address is the next sequential PC.
                wb_data = bus.PC + DATA_W'(4);
                wb_addr = ADDR_W'(LINK_REG);
            end
            WbSelMem: wb_data = bus.ReadDataRam;
            default:  wb_data = bus.AluResult;
        endcase
        wb_en = bus.ControlSignals[CTL_REGWRITE] && (wb_addr != ADDR_W'(ZERO_REG));
    end

    regfile_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile_core (
        .clk      (clk),
        .reset    (reset),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr1_i (bus.ReadAddr1),
        .raddr2_i (bus.ReadAddr2),
        .rdata1_o (bus.ReadData1),
        .rdata2_o (bus.ReadData2)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (bus.Instruction != DATA_W'(NOP_INSTR)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.WbData       = wb_data;
    assign bus.WbAddr       = wb_addr;
    assign bus.WbEnable     = wb_en;
    assign bus.RetiredCount = cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed table, reset and wrap
// sequences, then random traffic against an architectural register model.
module tb_writeback_regfile;

    logic clk;
    logic reset;

    writeback_regfile_if bus ();
    writeback_regfile_if #(.CNT_W(4)) bus4 ();

    writeback_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    writeback_regfile #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] ctl, input logic [4:0] dest, input logic [31:0] alu,
                         input logic [31:0] ram, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        bus.ControlSignals = ctl;
        bus.RegDestAddress = dest;
        bus.AluResult      = alu;
        bus.ReadDataRam    = ram;
        bus.PC             = pc;
        bus.Instruction    = instr;
        bus.ReadAddr1      = ra1;
        bus.ReadAddr2      = ra2;
    endtask

    typedef struct {
        logic [2:0]  ctl;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] ram;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e_data;
        logic [4:0]  e_addr;
        logic        e_en;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[8];

    // Reference model state.
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        drive(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0);
        bus4.ControlSignals = 3'b000;
        bus4.RegDestAddress = 5'd0;
        bus4.AluResult      = 32'h0;
        bus4.ReadDataRam    = 32'h0;
        bus4.PC             = 32'h0;
        bus4.Instruction    = 32'h0;
        bus4.ReadAddr1      = 5'd0;
        bus4.ReadAddr2      = 5'd0;

        // ctl, dest, alu, ram, pc, instr, ra1, ra2 | data, addr, en, rd1, rd2, count-after-edge
        vecs[0] = '{3'b001, 5'd8, 32'h12345678, 32'h0, 32'h0, 32'h1, 5'd8, 5'd0,
                    32'h12345678, 5'd8, 1'b1, 32'h12345678, 32'h0, 32'd1};
        vecs[1] = '{3'b011, 5'd9, 32'h1, 32'hCAFEF00D, 32'h0, 32'h2, 5'd8, 5'd9,
                    32'hCAFEF00D, 5'd9, 1'b1, 32'h12345678, 32'hCAFEF00D, 32'd2};
        vecs[2] = '{3'b101, 5'd3, 32'h7, 32'h0, 32'h00400020, 32'h3, 5'd31, 5'd3,
                    32'h00400024, 5'd31, 1'b1, 32'h00400024, 32'h0, 32'd3};
        vecs[3] = '{3'b001, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0,
                    32'hFFFFFFFF, 5'd0, 1'b0, 32'h0, 32'h0, 32'd3};
        vecs[4] = '{3'b100, 5'd5, 32'h0, 32'h0, 32'h00000100, 32'h0, 5'd31, 5'd3,
                    32'h00000104, 5'd31, 1'b0, 32'h00400024, 32'h0, 32'd3};
        vecs[5] = '{3'b000, 5'd8, 32'h55, 32'h0, 32'h0, 32'h4, 5'd8, 5'd9,
                    32'h55, 5'd8, 1'b0, 32'h12345678, 32'hCAFEF00D, 32'd4};
        vecs[6] = '{3'b111, 5'd4, 32'h0, 32'hAAAA, 32'hFFFFFFFC, 32'h5, 5'd31, 5'd4,
                    32'h0, 5'd31, 1'b1, 32'h0, 32'h0, 32'd5};
        vecs[7] = '{3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd9,
                    32'h0, 5'd0, 1'b0, 32'h0, 32'hCAFEF00D, 32'd5};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd1", bus.ReadData1, 32'h0);
        chk("reset_cnt", bus.RetiredCount, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].ctl, vecs[i].dest, vecs[i].alu, vecs[i].ram, vecs[i].pc,
                  vecs[i].instr, vecs[i].ra1, vecs[i].ra2);
            #1;
            chk($sformatf("v%0d_wbdata", i), bus.WbData, vecs[i].e_data);
            chk($sformatf("v%0d_wbaddr", i), 32'(bus.WbAddr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_wben", i), 32'(bus.WbEnable), 32'(vecs[i].e_en));
            chk($sformatf("v%0d_rd1", i), bus.ReadData1, vecs[i].e_rd1);
            chk($sformatf("v%0d_rd2", i), bus.ReadData2, vecs[i].e_rd2);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cnt", i), bus.RetiredCount, vecs[i].e_cnt);
        end
        // r0 write attempt must leave r0 reading zero after the edge too.
        @(negedge clk);
        drive(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        #1;
        chk("r0_after_rd1", bus.ReadData1, 32'h0);
        chk("r0_after_rd2", bus.ReadData2, 32'h0);

        // Asynchronous reset mid-cycle with nonzero registers.
        @(negedge clk);
        drive(3'b001, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 32'h9, 5'd5, 5'd9);
        @(posedge clk);
        #1;
        drive(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd9);
        #1;
        chk("pre_rst_r5", bus.ReadData1, 32'hDEADBEEF);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_r5", bus.ReadData1, 32'h0);
        chk("async_rst_r9", bus.ReadData2, 32'h0);
        chk("async_rst_cnt", bus.RetiredCount, 32'h0);
        // X on inputs while held in reset.
        bus.ControlSignals = 'x;
        bus.RegDestAddress = 'x;
        bus.AluResult      = 'x;
        bus.Instruction    = 'x;
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd8);
        reset = 1'b1;
        #1;
        chk("x_rst_r5", bus.ReadData1, 32'h0);
        chk("x_rst_r8", bus.ReadData2, 32'h0);
        @(posedge clk);
        #1;
        chk("x_rst_cnt", bus.RetiredCount, 32'h0);

        // Retire counter wrap on the 4-bit instance.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus4.Instruction = 32'h20000000 + 32'(i);
        end
        @(posedge clk);
        #1;
        chk("wrap_pre", 32'(bus4.RetiredCount), 32'hF);
        @(negedge clk);
        bus4.Instruction = 32'h0;
        @(posedge clk);
        #1;
        chk("wrap_hold", 32'(bus4.RetiredCount), 32'hF);
        @(negedge clk);
        bus4.Instruction = 32'h1;
        @(posedge clk);
        #1;
        chk("wrap_zero", 32'(bus4.RetiredCount), 32'h0);
        @(negedge clk);
        bus4.Instruction = 32'h0;

        // Random traffic against the architectural model, from a fresh reset.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_cnt = 32'h0;
        for (int c = 0; c < 300; c++) begin
            logic [2:0]  ctl;
            logic [4:0]  dest, ra1, ra2, e_addr;
            logic [31:0] alu, ram, pc, instr, e_data, e_rd1, e_rd2;
            logic        e_en;
            ctl   = 3'($urandom_range(0, 7));
            dest  = 5'($urandom_range(0, 31));
            alu   = $urandom;
            ram   = $urandom;
            pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
            instr = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1);
            ra1   = ($urandom_range(0, 3) == 0) ? dest : 5'($urandom_range(0, 31));
            ra2   = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            if (ctl[2]) begin
                e_data = pc + 32'd4;
                e_addr = 5'd31;
            end else begin
                e_data = ctl[1] ? ram : alu;
                e_addr = dest;
            end
            e_en  = ctl[0] && (e_addr != 5'd0);
            e_rd1 = (ra1 == 5'd0) ? 32'h0 : ((e_en && ra1 == e_addr) ? e_data : m_regs[ra1]);
            e_rd2 = (ra2 == 5'd0) ? 32'h0 : ((e_en && ra2 == e_addr) ? e_data : m_regs[ra2]);
            @(negedge clk);
            drive(ctl, dest, alu, ram, pc, instr, ra1, ra2);
            #1;
            chk("rnd_wbdata", bus.WbData, e_data);
            chk("rnd_wbaddr", 32'(bus.WbAddr), 32'(e_addr));
            chk("rnd_wben", 32'(bus.WbEnable), 32'(e_en));
            chk("rnd_rd1", bus.ReadData1, e_rd1);
            chk("rnd_rd2", bus.ReadData2, e_rd2);
            @(posedge clk);
            #1;
            if (e_en) m_regs[e_addr] = e_data;
            if (instr != 32'h0) m_cnt = m_cnt + 32'd1;
            chk("rnd_cnt", bus.RetiredCount, m_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
